scratchpad_cache_ctrl: RTL and testbench

SCRATCHPAD_CACHE_CTRL -- requirements
Module: scratchpad_cache_ctrl

---
 rtl/scratchpad_cache_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_scratchpad_cache_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_cache_ctrl.sv
// Direct-mapped write-back scratchpad cache in front of a word-addressed memory region.
// Serves kernel reads/writes, fills and evicts lines, and flushes dirty lines on k_done.
module scratchpad_cache_ctrl #(
    parameter int DATA_WID   = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         base,
    input  logic [63:0]         num_words,
    input  logic                k_rd_req,
    input  logic [63:0]         k_rd_addr,
    output logic                k_rd_ready,
    output logic [DATA_WID-1:0] k_rd_data,
    input  logic                k_wr_req,
    input  logic [63:0]         k_wr_addr,
    input  logic [DATA_WID-1:0] k_wr_data,
    output logic                k_wr_ready,
    input  logic                k_done,
    output logic                m_rd_en,
    output logic [63:0]         m_rd_addr,
    input  logic                m_rd_valid,
    input  logic [DATA_WID-1:0] m_rd_data,
    output logic                m_wr_en,
    output logic [63:0]         m_wr_addr,
    output logic [DATA_WID-1:0] m_wr_data,
    input  logic                m_wr_ready,
    output logic                done,
    output logic [31:0]         miss_cnt
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [63:0] LW64 = 64'(LINE_WORDS);
    localparam logic [63:0] NL64 = 64'(NUM_LINES);

    typedef enum logic [2:0] {IDLE, EVICT, FILL, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [NUM_LINES-1:0] valid, dirty;
    logic [63:0]          tags [NUM_LINES];
    logic [DATA_WID-1:0]  data [NUM_LINES][LINE_WORDS];

    logic [IDX_W-1:0]  cur_idx;
    logic [WORD_W-1:0] word;
    logic [63:0]       fill_tag;
    logic              done_pend;

    logic              rd_pend, wr_pend, serve;
    logic [63:0]       req_addr, req_off, req_tag;
    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic              req_in, req_hit, wr_hit_go;

    logic [63:0]       wb_tag, mem_off, mem_addr;
    logic              mem_in, last_word, last_line;
    logic              word_adv, line_adv;

    // A request whose ack is already on the port is still held this cycle; don't serve it twice.
    assign rd_pend   = k_rd_req && !k_rd_ready;
    assign wr_pend   = k_wr_req && !k_wr_ready;
    assign serve     = rd_pend || wr_pend;
    assign last_word = (word == WORD_W'(LINE_WORDS - 1));
    assign last_line = (cur_idx == IDX_W'(NUM_LINES - 1));
    assign done      = (state == DONE);

    always_comb begin
        req_addr  = rd_pend ? k_rd_addr : k_wr_addr;
        req_off   = (req_addr - base) >> 2;
        req_in    = (req_addr >= base) && (req_off < num_words);
        req_word  = WORD_W'(req_off % LW64);
        req_idx   = IDX_W'((req_off / LW64) % NL64);
        req_tag   = req_off / (LW64 * NL64);
        req_hit   = valid[req_idx] && (tags[req_idx] == req_tag);
        wr_hit_go = serve && !rd_pend && req_in && req_hit;
    end

    // Memory-side word offset of the line being moved: fill uses the new tag, writeback the resident one.
    always_comb begin
        wb_tag   = (state == FILL) ? fill_tag : tags[cur_idx];
        mem_off  = (wb_tag * NL64 + 64'(cur_idx)) * LW64 + 64'(word);
        mem_in   = (mem_off < num_words);
        mem_addr = base + (mem_off << 2);
    end

    always_comb begin
        state_nxt = state;
        m_rd_en   = 1'b0;
        m_rd_addr = '0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        word_adv  = 1'b0;
        line_adv  = 1'b0;
        case (state)
            IDLE: begin
                if (serve) begin
                    if (req_in && !req_hit)
                        state_nxt = (valid[req_idx] && dirty[req_idx]) ? EVICT : FILL;
                end else if (k_done || done_pend) begin
                    state_nxt = FLUSH;
                end
            end
            EVICT: begin
                if (mem_in) begin
                    m_wr_en   = 1'b1;
                    m_wr_addr = mem_addr;
                    m_wr_data = data[cur_idx][word];
                    word_adv  = m_wr_ready;
                end else begin
                    word_adv = 1'b1;
                end
                if (word_adv && last_word) state_nxt = FILL;
            end
            FILL: begin
                if (mem_in) begin
                    m_rd_en   = 1'b1;
                    m_rd_addr = mem_addr;
                    word_adv  = m_rd_valid;
                end else begin
                    word_adv = 1'b1;
                end
                if (word_adv && last_word) state_nxt = IDLE;
            end
            FLUSH: begin
                if (valid[cur_idx] && dirty[cur_idx]) begin
                    if (mem_in) begin
                        m_wr_en   = 1'b1;
                        m_wr_addr = mem_addr;
                        m_wr_data = data[cur_idx][word];
                        word_adv  = m_wr_ready;
                    end else begin
                        word_adv = 1'b1;
                    end
                    line_adv = word_adv && last_word;
                end else begin
                    line_adv = 1'b1;
                end
                if (line_adv && last_line) state_nxt = DONE;
            end
            DONE: ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            miss_cnt   <= '0;
            k_rd_ready <= 1'b0;
            k_wr_ready <= 1'b0;
            k_rd_data  <= '0;
            cur_idx    <= '0;
            word       <= '0;
            fill_tag   <= '0;
            done_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            k_rd_ready <= 1'b0;
            k_wr_ready <= 1'b0;
            done_pend  <= done_pend | k_done;
            case (state)
                IDLE: begin
                    if (serve) begin
                        if (!req_in || req_hit) begin
                            if (rd_pend) begin
                                k_rd_ready <= 1'b1;
                                k_rd_data  <= req_in ? data[req_idx][req_word] : '0;
                            end else begin
                                k_wr_ready <= 1'b1;
                                if (req_in) dirty[req_idx] <= 1'b1;
                            end
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                            cur_idx  <= req_idx;
                            fill_tag <= req_tag;
                            word     <= '0;
                        end
                    end else begin
                        cur_idx <= '0;
                        word    <= '0;
                    end
                end
                EVICT: if (word_adv) word <= word + 1'b1;
                FILL: begin
                    if (word_adv) begin
                        word <= word + 1'b1;
                        if (last_word) begin
                            valid[cur_idx] <= 1'b1;
                            dirty[cur_idx] <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (line_adv) begin
                        cur_idx <= cur_idx + 1'b1;
                        word    <= '0;
                    end else if (word_adv) begin
                        word <= word + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && wr_hit_go)
            data[req_idx][req_word] <= k_wr_data;
        if (state == FILL && word_adv)
            data[cur_idx][word] <= mem_in ? m_rd_data : '0;
        if (state == FILL && word_adv && last_word)
            tags[cur_idx] <= fill_tag;
    end

endmodule

// File: tb/tb_scratchpad_cache_ctrl.sv
// Directed bench for scratchpad_cache_ctrl: flat-memory kernel model, line-residency miss
// model, and a backing-memory responder that logs all traffic.
module tb_scratchpad_cache_ctrl;

    localparam int DW = 32;
    localparam int LW = 4;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   base, num_words;
    logic          k_rd_req, k_rd_ready, k_wr_req, k_wr_ready, k_done;
    logic [63:0]   k_rd_addr, k_wr_addr;
    logic [DW-1:0] k_rd_data, k_wr_data;
    logic          m_rd_en, m_rd_valid, m_wr_en, m_wr_ready, done;
    logic [63:0]   m_rd_addr, m_wr_addr;
    logic [DW-1:0] m_rd_data, m_wr_data;
    logic [31:0]   miss_cnt;

    always #5 clk = ~clk;

    scratchpad_cache_ctrl #(.DATA_WID(DW), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .clk(clk), .reset(reset), .base(base), .num_words(num_words),
        .k_rd_req(k_rd_req), .k_rd_addr(k_rd_addr), .k_rd_ready(k_rd_ready), .k_rd_data(k_rd_data),
        .k_wr_req(k_wr_req), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data), .k_wr_ready(k_wr_ready),
        .k_done(k_done),
        .m_rd_en(m_rd_en), .m_rd_addr(m_rd_addr), .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
        .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_ready(m_wr_ready),
        .done(done), .miss_cnt(miss_cnt)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] bmem   [256];
    logic [31:0] shadow [256];
    logic [63:0] rd_log [$];
    logic [63:0] wr_alog [$];
    logic [31:0] wr_dlog [$];
    longint      resident [NL];
    int          model_miss;
    logic [31:0] exp_rd;
    bit          stall;
    bit          prev_rd, prev_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        w = (a - 64'h1000) >> 2;
        if (a >= 64'h1000 && w < 64'd256) return bmem[int'(w)];
        return 32'hBAD0BAD0;
    endfunction

    function automatic bit in_region(input logic [63:0] a);
        return (a >= base) && (((a - base) >> 2) < num_words);
    endfunction

    function automatic logic [31:0] expected(input logic [63:0] a);
        if (!in_region(a)) return '0;
        return shadow[int'((a - base) >> 2)];
    endfunction

    // Residency model: which memory line each index holds; a different line means a miss.
    task automatic model_access(input logic [63:0] a);
        longint ln;
        int     idx;
        if (in_region(a)) begin
            ln  = longint'(((a - base) >> 2) / LW);
            idx = int'(ln % NL);
            if (resident[idx] != ln) begin
                model_miss++;
                resident[idx] = ln;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) resident[i] = -1;
        model_miss = 0;
        for (int i = 0; i < 256; i++) shadow[i] = bmem[i];
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_alog.delete();
        wr_dlog.delete();
    endtask

    // Backing memory: always ready, read data returned while not stalled.
    always @(negedge clk) begin
        m_rd_valid = m_rd_en && !stall && !reset;
        m_rd_data  = m_rd_en ? mem_word(m_rd_addr) : '0;
        if (m_rd_valid) rd_log.push_back(m_rd_addr);
        m_wr_ready = m_wr_en && !reset;
        if (m_wr_ready) begin
            wr_alog.push_back(m_wr_addr);
            wr_dlog.push_back(m_wr_data);
            if (m_wr_addr >= 64'h1000 && ((m_wr_addr - 64'h1000) >> 2) < 64'd256)
                bmem[int'((m_wr_addr - 64'h1000) >> 2)] = m_wr_data;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (m_rd_en || m_wr_en) check("mem_excl", 64'(m_rd_en && m_wr_en), 64'd0);
            if (done) check("done_quiet", 64'({m_rd_en, m_wr_en}), 64'd0);
            if (k_rd_ready) begin
                check("rd_data", 64'(k_rd_data), 64'(exp_rd));
                check("rd_miss_cnt", 64'(miss_cnt), 64'(model_miss));
                check("rd_single_pulse", 64'(prev_rd), 64'd0);
            end
            if (k_wr_ready) begin
                check("wr_miss_cnt", 64'(miss_cnt), 64'(model_miss));
                check("wr_single_pulse", 64'(prev_wr), 64'd0);
            end
            prev_rd = k_rd_ready;
            prev_wr = k_wr_ready;
        end
    end

    task automatic do_read(input logic [63:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        exp_rd = expected(a);
        model_access(a);
        k_rd_addr = a;
        k_rd_req  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!k_rd_ready && lat < 200);
        check("rd_ack_seen", 64'(k_rd_ready), 64'd1);
        d = k_rd_data;
        k_rd_req = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [31:0] v, output int lat);
        @(negedge clk);
        model_access(a);
        if (in_region(a)) shadow[int'((a - base) >> 2)] = v;
        k_wr_addr = a;
        k_wr_data = v;
        k_wr_req  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!k_wr_ready && lat < 200);
        check("wr_ack_seen", 64'(k_wr_ready), 64'd1);
        k_wr_req = 1'b0;
    endtask

    task automatic do_both(input logic [63:0] ra, input logic [63:0] wa, input logic [31:0] v,
                           output int rl, output int wl);
        int n;
        @(negedge clk);
        exp_rd = expected(ra);
        model_access(ra);
        model_access(wa);
        if (in_region(wa)) shadow[int'((wa - base) >> 2)] = v;
        k_rd_addr = ra; k_rd_req = 1'b1;
        k_wr_addr = wa; k_wr_data = v; k_wr_req = 1'b1;
        rl = 0; wl = 0; n = 0;
        while ((rl == 0 || wl == 0) && n < 200) begin
            @(negedge clk);
            n++;
            if (k_rd_ready && rl == 0) begin rl = n; k_rd_req = 1'b0; end
            if (k_wr_ready && wl == 0) begin wl = n; k_wr_req = 1'b0; end
        end
        k_rd_req = 1'b0;
        k_wr_req = 1'b0;
    endtask

    task automatic do_reset(input logic [63:0] nw);
        reset = 1'b1;
        k_rd_req = 1'b0;
        k_wr_req = 1'b0;
        k_done = 1'b0;
        num_words = nw;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_k_rd_ready"}, 64'(k_rd_ready), 64'd0);
        check({tag, "_k_wr_ready"}, 64'(k_wr_ready), 64'd0);
        check({tag, "_k_rd_data"}, 64'(k_rd_data), 64'd0);
        check({tag, "_m_rd"}, {63'd0, m_rd_en} | m_rd_addr, 64'd0);
        check({tag, "_m_wr"}, {63'd0, m_wr_en} | m_wr_addr | 64'(m_wr_data), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_miss_cnt"}, 64'(miss_cnt), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        int lat, rl, wl, n, acks;

        reset = 1'b1; base = 64'h1000; num_words = 64'd64; stall = 1'b0;
        k_rd_req = 1'b0; k_rd_addr = '0; k_wr_req = 1'b0; k_wr_addr = '0; k_wr_data = '0; k_done = 1'b0;
        m_rd_valid = 1'b0; m_rd_data = '0; m_wr_ready = 1'b0;
        for (int i = 0; i < 256; i++) bmem[i] = 32'hC0DE0000 + 32'(i);
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        reset = 1'b0;
        model_reset();

        // Cold read
        clear_logs();
        do_read(64'h1008, d, lat);
        check("cold_data", 64'(d), 64'hC0DE0002);
        check("cold_miss_cnt", 64'(miss_cnt), 64'd1);
        check("cold_fill_words", 64'(rd_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < rd_log.size(); k++)
            check("cold_fill_addr", rd_log[k], 64'h1000 + 64'(4 * k));
        check("cold_no_wr", 64'(wr_alog.size()), 64'd0);

        // Hit latency
        clear_logs();
        do_read(64'h1004, d, lat);
        check("hit_lat", 64'(lat), 64'd1);
        check("hit_data", 64'(d), 64'hC0DE0001);
        check("hit_miss_cnt", 64'(miss_cnt), 64'd1);
        check("hit_no_traffic", 64'(rd_log.size() + wr_alog.size()), 64'd0);

        // Dirty eviction
        do_write(64'h1000, 32'hA5, lat);
        check("wr_hit_lat", 64'(lat), 64'd1);
        clear_logs();
        do_read(64'h1040, d, lat);
        check("evict_new_data", 64'(d), 64'hC0DE0010);
        check("evict_miss_cnt", 64'(miss_cnt), 64'd2);
        check("evict_wr_words", 64'(wr_alog.size()), 64'd4);
        for (int k = 0; k < 4 && k < wr_alog.size(); k++) begin
            check("evict_wr_addr", wr_alog[k], 64'h1000 + 64'(4 * k));
            check("evict_wr_data", 64'(wr_dlog[k]), (k == 0) ? 64'hA5 : 64'hC0DE0000 + 64'(k));
        end
        check("evict_fill_words", 64'(rd_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < rd_log.size(); k++)
            check("evict_fill_addr", rd_log[k], 64'h1040 + 64'(4 * k));
        clear_logs();
        do_read(64'h1000, d, lat);
        check("written_back_data", 64'(d), 64'hA5);
        check("refetch_no_wr", 64'(wr_alog.size()), 64'd0);

        // Simultaneous read and write: read first
        do_both(64'h1008, 64'h1008, 32'h5A5A, rl, wl);
        check("both_rd_lat", 64'(rl), 64'd1);
        check("both_wr_after_rd", 64'(wl > rl), 64'd1);
        do_read(64'h1008, d, lat);
        check("both_wr_visible", 64'(d), 64'h5A5A);

        // Out-of-region accesses
        clear_logs();
        do_read(64'h0FFC, d, lat);
        check("below_lat", 64'(lat), 64'd1);
        check("below_data", 64'(d), 64'd0);
        do_write(64'h1100, 32'hFFFF, lat);
        check("above_wr_lat", 64'(lat), 64'd1);
        do_read(64'h1100, d, lat);
        check("above_rd_data", 64'(d), 64'd0);
        check("oor_no_traffic", 64'(rd_log.size() + wr_alog.size()), 64'd0);
        check("oor_miss_cnt", 64'(miss_cnt), 64'd3);

        // Region clip
        do_reset(64'd6);
        clear_logs();
        do_read(64'h1010, d, lat);
        check("clip_data", 64'(d), 64'hC0DE0004);
        check("clip_fill_words", 64'(rd_log.size()), 64'd2);
        for (int k = 0; k < 2 && k < rd_log.size(); k++)
            check("clip_fill_addr", rd_log[k], 64'h1010 + 64'(4 * k));
        clear_logs();
        do_read(64'h1018, d, lat);
        check("clip_oor_data", 64'(d), 64'd0);
        check("clip_oor_lat", 64'(lat), 64'd1);
        check("clip_oor_traffic", 64'(rd_log.size()), 64'd0);

        // Flush
        do_reset(64'd64);
        do_write(64'h1000, 32'h11, lat);
        do_write(64'h1020, 32'h22, lat);
        do_read(64'h1010, d, lat);
        clear_logs();
        @(negedge clk);
        k_done = 1'b1;
        @(negedge clk);
        k_done = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("flush_done", 64'(done), 64'd1);
        check("flush_wr_words", 64'(wr_alog.size()), 64'd8);
        for (int k = 0; k < 8 && k < wr_alog.size(); k++) begin
            check("flush_wr_addr", wr_alog[k], ((k < 4) ? 64'h1000 : 64'h1010) + 64'(4 * k));
            check("flush_wr_data", 64'(wr_dlog[k]), 64'(shadow[(k < 4) ? k : k + 4]));
        end
        if (wr_dlog.size() >= 5) begin
            check("flush_line0_word0", 64'(wr_dlog[0]), 64'h11);
            check("flush_line2_word0", 64'(wr_dlog[4]), 64'h22);
        end
        check("flush_no_rd", 64'(rd_log.size()), 64'd0);
        clear_logs();
        k_rd_addr = 64'h1000; k_rd_req = 1'b1;
        k_wr_addr = 64'h1004; k_wr_data = 32'h77; k_wr_req = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (k_rd_ready || k_wr_ready) acks++;
        end
        k_rd_req = 1'b0; k_wr_req = 1'b0;
        check("done_ignores_acks", 64'(acks), 64'd0);
        check("done_ignores_traffic", 64'(rd_log.size() + wr_alog.size()), 64'd0);
        check("done_held", 64'(done), 64'd1);

        // Reset mid-fill
        do_reset(64'd64);
        stall = 1'b1;
        @(negedge clk);
        k_rd_addr = 64'h1008;
        k_rd_req = 1'b1;
        n = 0;
        while (!m_rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fill_started", 64'(m_rd_en), 64'd1);
        check("fill_miss_counted", 64'(miss_cnt), 64'd1);
        reset = 1'b1;
        #1;
        check_outputs_zero("midfill");
        k_rd_req = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        clear_logs();
        do_read(64'h1008, d, lat);
        check("after_rst_miss_cnt", 64'(miss_cnt), 64'd1);
        check("after_rst_fill_words", 64'(rd_log.size()), 64'd4);
        check("after_rst_data", 64'(d), 64'hC0DE0002);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
